// File: rtl/ref_clock_gen.sv
// Reference clock generator: produces a square-wave clkOut whose half-period is
// programmable, with one-shot phase advance/retard of a single high half and
// run/stop control. Commands go through a one-entry pending register and take
// effect at the boundary cycle (the cycle in which clkOut rises).
module ref_clock_gen #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_HALF = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [1:0]       cmdType,
    input  logic [WIDTH-1:0] cmdData,
    output logic             clkOut,
    output logic             risePulse,
    output logic             running
);

    typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

    localparam logic [1:0] CMD_SET = 2'b00;
    localparam logic [1:0] CMD_ADV = 2'b01;
    localparam logic [1:0] CMD_RET = 2'b10;
    localparam logic [1:0] CMD_RUN = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [WIDTH-1:0]   half_q, half_d;
    logic               clk_q, clk_d;
    logic               rise_q, rise_d;
    logic               pend_vld_q, pend_vld_d;
    logic [1:0]         pend_type_q;
    logic [WIDTH-1:0]   pend_data_q;
    logic               accept;
    logic               at_limit;

    // A half-period of zero would stall the counter, so it becomes one.
    function automatic logic [WIDTH-1:0] clamp_half(input logic [WIDTH-1:0] d);
        return (d == '0) ? WIDTH'(1) : d;
    endfunction

    // Shortened half, never below one cycle.
    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return (b >= a) ? WIDTH'(1) : (a - b);
    endfunction

    // Lengthened half, pinned at the counter's maximum instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    assign cmdReady  = !pend_vld_q;
    assign clkOut    = clk_q;
    assign risePulse = rise_q;
    assign running   = (state_q == RUN);
    assign accept    = cmdValid && !pend_vld_q;
    assign at_limit  = (count_q == (limit_q - WIDTH'(1)));

    // Next-state logic: counter, toggling, and command application.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        half_d     = half_q;
        clk_d      = clk_q;
        rise_d     = 1'b0;
        pend_vld_d = pend_vld_q;
        if (accept) begin
            pend_vld_d = 1'b1;
        end
        case (state_q)
            STOP: begin
                count_d = '0;
                clk_d   = 1'b0;
                if (pend_vld_q) begin
                    pend_vld_d = 1'b0;
                    case (pend_type_q)
                        CMD_SET: begin
                            half_d  = clamp_half(pend_data_q);
                            limit_d = clamp_half(pend_data_q);
                        end
                        CMD_RUN: begin
                            if (pend_data_q[0]) begin
                                state_d = RUN;
                                limit_d = half_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (at_limit) begin
                    count_d = '0;
                    limit_d = half_q;
                    if (clk_q) begin
                        clk_d = 1'b0;
                    end else begin
                        // Boundary cycle: clkOut rises unless a stop lands here.
                        clk_d  = 1'b1;
                        rise_d = 1'b1;
                        if (pend_vld_q) begin
                            pend_vld_d = 1'b0;
                            case (pend_type_q)
                                CMD_SET: begin
                                    half_d  = clamp_half(pend_data_q);
                                    limit_d = clamp_half(pend_data_q);
                                end
                                CMD_ADV: limit_d = sat_sub(half_q, pend_data_q);
                                CMD_RET: limit_d = sat_add(half_q, pend_data_q);
                                CMD_RUN: begin
                                    if (!pend_data_q[0]) begin
                                        state_d = STOP;
                                        clk_d   = 1'b0;
                                        rise_d  = 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: state_d = STOP;
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= STOP;
            count_q    <= '0;
            limit_q    <= WIDTH'(DEFAULT_HALF);
            half_q     <= WIDTH'(DEFAULT_HALF);
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            half_q     <= half_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Pending command payload; qualified by pend_vld_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_type_q <= cmdType;
            pend_data_q <= cmdData;
        end
    end

endmodule
